pc_sequencer: RTL

Instruction sequencer for the 32-bit DLX datapath. It owns the program counter and fetches each instruction from instruction memory over a req/ack handshake. It presents the fetched word to the instruction decoder and consumes the decoder's control-flow outputs (`branch_z`, `branch_nz`, `jmp`, `jmp_r`) together with register bus A to select the next PC. It is the consumer side of the decoder's branch/jump interface and sits between instruction memory and the decode/execute datapath.

---
 rtl/pc_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - DLX PC sequencer: fetch over req/ack, execute handshake, next-PC select.
// Optional return-address link output enabled by defining PC_SEQ_LINK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic        branch_z,
    input  logic        branch_nz,
    input  logic        jmp,
    input  logic        jmp_r,
    input  logic [31:0] reg_a,
    output logic [31:0] pc,
    output logic        link_wr,
    output logic [31:0] link_data,
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [5:0] OP_TRAP = 6'h11;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        br_taken;
    logic        is_trap;

    assign pc4      = pc_q + 32'd4;
    assign br_taken = (branch_z & (reg_a == 32'd0)) | (branch_nz & (reg_a != 32'd0));
    assign is_trap  = (inst_q[31:26] == OP_TRAP);

    // Offsets are byte offsets added to pc+4 without shifting.
    always_comb begin
        next_pc = pc4;
        if (jmp_r)
            next_pc = {reg_a[31:2], 2'b00};
        else if (jmp)
            next_pc = pc4 + {{6{inst_q[25]}}, inst_q[25:0]};
        else if (br_taken)
            next_pc = pc4 + {{16{inst_q[15]}}, inst_q[15:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            inst_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == FETCH && imem_ack)
                inst_q <= imem_rdata;
            if (state == EXEC && exec_done && !is_trap)
                pc_q <= next_pc;
        end
    end

    always_comb begin
        state_nx   = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nx = EXEC;
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (exec_done)
                    state_nx = is_trap ? HALT : FETCH;
            end
            HALT: halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;

`ifdef PC_SEQ_LINK_EN
    assign link_wr   = inst_valid & exec_done &
                       ((inst_q[31:26] == 6'h03) | (inst_q[31:26] == 6'h13));
    assign link_data = inst_valid ? pc4 : 32'd0;
`else
    assign link_wr   = 1'b0;
    assign link_data = 32'd0;
`endif

endmodule
